// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one fixed-latency memory port between the instruction-fetch path
// and the load/store path. Each access goes through IDLE -> BUSY -> ACK. The
// pipeline stall vector is held while a request is still outstanding.
//
// Ports
//   clk, rst          core clock; asynchronous active-high reset
//   if_req_i/addr_i   fetch request (level, held until if_ack_o) and address
//   if_rdata_o        fetched word, held until the next fetch completes
//   if_ack_o          one-cycle fetch completion pulse
//   dm_req_i/we_i/sel_i/addr_i/wdata_i
//                     data request (level, held until dm_ack_o) and its fields
//   dm_rdata_o        load data, held until the next data access completes
//   dm_ack_o          one-cycle data completion pulse
//   bus_*_o           registered memory port: chip/write enable, byte enables,
//                     address, write data
//   bus_rdata_i       memory read data, sampled when the wait counter expires
//   stall_o           hold vector: bit0 PC, 1 IF/ID, 2 ID, 3 EX, 4 MEM, 5 WB
module mem_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [3:0]  dm_sel_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_ack_o,
  output logic        bus_ce_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  output logic [5:0]  stall_o
);

  if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 16)) begin : g_bad_wait_cycles
    $fatal(1, "mem_arbiter: WAIT_CYCLES must be in 1..16");
  end

  // The counter is loaded with WAIT_CYCLES-1, so bus_ce_o stays high for
  // exactly WAIT_CYCLES cycles.
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;       // 0 fetch, 1 data
  logic        bus_ce_q, bus_ce_d;
  logic        bus_we_q, bus_we_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        if_ack_q, if_ack_d;
  logic        dm_ack_q, dm_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    bus_ce_d    = bus_ce_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    // Acks are only ever set on the BUSY->ACK transition, so they
    // self-clear one cycle later.
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Data wins: the MEM-stage instruction is older. Fetch cannot starve
        // because the stall vector freezes new instructions.
        if (dm_req_i) begin
          owner_d     = 1'b1;
          bus_ce_d    = 1'b1;
          bus_we_d    = dm_we_i;
          bus_sel_d   = dm_sel_i;
          bus_addr_d  = dm_addr_i;
          bus_wdata_d = dm_wdata_i;
          cnt_d       = CNT_LOAD;
          state_d     = BUSY;
        end else if (if_req_i) begin
          owner_d     = 1'b0;
          bus_ce_d    = 1'b1;
          bus_we_d    = 1'b0;
          bus_sel_d   = 4'hF;
          bus_addr_d  = if_addr_i;
          bus_wdata_d = 32'h0;
          cnt_d       = CNT_LOAD;
          state_d     = BUSY;
        end else begin
          bus_ce_d    = 1'b0;
        end
      end
      BUSY: begin
        // The request inputs are ignored here. A requester that drops its
        // request mid-access still sees the access finish, so a store is
        // never torn.
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (owner_q) begin
            dm_rdata_d = bus_rdata_i;
            dm_ack_d   = 1'b1;
          end else begin
            if_rdata_d = bus_rdata_i;
            if_ack_d   = 1'b1;
          end
          bus_ce_d = 1'b0;
          bus_we_d = 1'b0;
          state_d  = ACK;
        end
      end
      ACK: begin
        // Requests are not sampled here. The requester drops its level
        // during this cycle, so it cannot be granted twice.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      owner_q     <= 1'b0;
      bus_ce_q    <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= 4'h0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= 32'h0;
      dm_rdata_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      bus_ce_q    <= bus_ce_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  // The stall releases in the ack cycle, so the pipeline advances on the
  // edge that ends that cycle. The stall is held low while in reset.
  always_comb begin
    stall_o = 6'b000000;
    if (!rst) begin
      if (dm_req_i && !dm_ack_q) begin
        stall_o = 6'b011111;
      end else if (if_req_i && !if_ack_q) begin
        stall_o = 6'b000111;
      end
    end
  end

  assign bus_ce_o    = bus_ce_q;
  assign bus_we_o    = bus_we_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and stall controller for the five-stage core. Shares one synchronous-latency memory port between the instruction-fetch path (PC stage) and the load/store path (MEM stage), sequences each access through a wait-state FSM, and drives the pipeline stall vector while an access is outstanding. Sits between the core's fetch/MEM request signals and the external memory bus.

## Interface
- WAIT_CYCLES, 1, memory access latency in cycles; legal range 1..16
- clk  in  1  core clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req_i  in  1  fetch request, level, held until if_ack_o
- if_addr_i  in  32  fetch byte address
- if_rdata_o  out  32  fetched word, valid in ack cycle, held until next fetch completes
- if_ack_o  out  1  one-cycle fetch completion pulse
- dm_req_i  in  1  data request, level, held until dm_ack_o
- dm_we_i  in  1  1 = store, 0 = load
- dm_sel_i  in  4  byte enables for store/load
- dm_addr_i  in  32  data byte address
- dm_wdata_i  in  32  store data
- dm_rdata_o  out  32  load data, valid in ack cycle, held until next data access completes
- dm_ack_o  out  1  one-cycle data completion pulse
- bus_ce_o  out  1  memory chip enable
- bus_we_o  out  1  memory write enable
- bus_sel_o  out  4  memory byte enables
- bus_addr_o  out  32  memory address
- bus_wdata_o  out  32  memory write data
- bus_rdata_i  in  32  memory read data, valid when counter expires
- stall_o  out  6  pipeline hold vector: bit0 PC, bit1 IF/ID, bit2 ID, bit3 EX, bit4 MEM, bit5 WB

## Operation
- FSM states IDLE, BUSY, ACK; 4-bit down-counter cnt; 1-bit owner register (0 fetch, 1 data).
- IDLE: at edge, if dm_req_i → owner=1, latch dm_addr/we/sel/wdata onto bus_* registers, bus_ce_o=1, cnt=WAIT_CYCLES-1, → BUSY. Else if if_req_i → owner=0, bus_addr_o=if_addr_i, bus_we_o=0, bus_sel_o=4'hF, bus_wdata_o=0, bus_ce_o=1, cnt=WAIT_CYCLES-1, → BUSY. Else stay, bus_ce_o=0.
- Fixed priority data > fetch: the MEM-stage instruction is older; fetch cannot starve because stall_o freezes new instructions.
- BUSY: cnt≠0 → cnt−1, bus outputs held. cnt==0 → capture bus_rdata_i into owner's rdata register (stores also capture, value don't-care to requester), pulse owner's ack, clear bus_ce_o/bus_we_o, → ACK.
- ACK: ack cleared at next edge, → IDLE. Requests are not sampled in ACK.
- Requester dropping req during BUSY: access still completes (no torn stores); ack still pulses; no retry.
- stall_o (combinational): dm_req_i & ~dm_ack_o → 6'b011111; else if_req_i & ~if_ack_o → 6'b000111; else 6'b000000. Forced 0 while rst.
- Non-owner rdata register never changes.

## Timing
- Reset values: state IDLE, cnt 0, all bus_* 0, both acks 0, both rdata 0, stall_o 0. Reset mid-BUSY aborts immediately; bus_ce_o drops asynchronously.
- Request seen in IDLE at cycle 0 → bus_ce_o high cycles 1..WAIT_CYCLES → ack high cycle WAIT_CYCLES+1 → IDLE cycle WAIT_CYCLES+2.
- Throughput: one access per WAIT_CYCLES+2 cycles; back-to-back data then fetch adds no extra gap.
- Stall releases in ack cycle, so pipeline advances on the edge ending the ack cycle; the next request is visible in IDLE.
- Simultaneous if_req_i and dm_req_i in IDLE: data granted first, fetch granted in the IDLE after data's ACK.
- WAIT_CYCLES outside 1..16: elaboration error.

## Test plan
- Reset: rst pulsed mid-BUSY with dm_req_i=1 → all outputs 0 same cycle, after release IDLE re-grants data, ack at cycle WAIT_CYCLES+1.
- Single fetch, WAIT_CYCLES=1: if_addr_i=0x0000_0040, bus_rdata_i=0x2401_0005 → bus_ce_o cycle 1, if_ack_o cycle 2, if_rdata_o=0x2401_0005, stall_o=6'b000111 cycles 0–1, 0 in cycle 2.
- Store, WAIT_CYCLES=3: dm_we_i=1, dm_sel_i=4'b0011, addr 0x100, wdata 0xDEAD_BEEF → bus_we_o=1, bus_sel_o=4'b0011 cycles 1–3, dm_ack_o cycle 4, stall_o=6'b011111 cycles 0–3.
- Contention: if_req_i and dm_req_i both rise cycle 0, WAIT_CYCLES=2 → data ack cycle 3, fetch granted cycle 5, fetch ack cycle 7; if_rdata_o unchanged until cycle 7.
- Drop mid-access: dm_req_i deasserted in BUSY cycle 2 of WAIT_CYCLES=4 load → bus_ce_o stays high through cycle 4, dm_ack_o pulses cycle 5, no second grant.
- Hold: after load returning 0x1234_5678, three fetches complete → dm_rdata_o stays 0x1234_5678 throughout.
